clock_div_gen: RTL
==================

CLOCK_DIV_GEN -- requirements
Module: clock_div_gen

Interface
REQ-001 SHALL have parameter W, default 8: width of divisor and phase inputs.
REQ-002 SHALL have parameter CW, default 16: width of the rising-edge counter.
REQ-003 SHALL have port master_clk  input  1  sole clock; all state changes on its posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  generator enable; low forces IDLE.
REQ-006 SHALL have port load  input  1  single-cycle request to latch div_in/phase_in and (re)start.
REQ-007 SHALL have port div_in  input  W  output period in master_clk cycles (D).
REQ-008 SHALL have port phase_in  input  W  start delay in master_clk cycles (P).
REQ-009 SHALL have port gen_clk  output  1  generated clock, registered.
REQ-010 SHALL have port gen_rise  output  1  one-cycle strobe, high in the cycle gen_clk is 1 after being 0.
REQ-011 SHALL have port locked  output  1  high while gen_clk is toggling with the latched config.
REQ-012 SHALL have port err  output  1  sticky config error flag.
REQ-013 SHALL have port edge_cnt  output  CW  count of gen_clk rising edges since last accepted load.

Function
REQ-014 SHALL implement states IDLE, ALIGN, RUN.
REQ-015 SHALL accept load only when en=1; load with en=0 is ignored.
REQ-016 SHALL treat config as invalid when D<2 or P>=D; invalid load sets err=1, returns to or stays in IDLE, and drives gen_clk=0 and locked=0.
REQ-017 SHALL, on valid load, latch D and P, clear err and edge_cnt, and move to ALIGN if P>0 or RUN if P=0.
REQ-018 SHALL hold gen_clk=0 in IDLE and ALIGN; ALIGN SHALL last exactly P cycles.
REQ-019 SHALL, with load sampled at posedge k, make gen_clk first 1 in the cycle after posedge k+1+P.
REQ-020 SHALL, in RUN, step phase counter cnt 0..D-1 and wrap to 0.
REQ-021 SHALL drive gen_clk=1 for cnt < ceil(D/2), else 0, so the high time is ceil(D/2) and the low time is floor(D/2) cycles.
REQ-022 SHALL assert gen_rise and increment edge_cnt on every gen_clk 0->1 transition; edge_cnt SHALL wrap modulo 2^CW.
REQ-023 SHALL assert locked together with the first gen_rise after a load and keep it high while in RUN.
REQ-024 SHALL, on load in RUN or ALIGN, restart per REQ-016/REQ-017: gen_clk=0 and locked=0 the next cycle, with no partial high pulse carried over.
REQ-025 SHALL, when en=0 in any state, go to IDLE next cycle with gen_clk=0, locked=0, and edge_cnt and err held; en=0 SHALL take priority over a simultaneous load.
REQ-026 SHALL ignore changes on div_in/phase_in except in the cycle load is accepted.

Reset
REQ-027 SHALL, while rst=1, force IDLE, gen_clk=0, gen_rise=0, locked=0, err=0, edge_cnt=0, and latched D/P=0, independent of master_clk.
REQ-028 SHALL, after rst deasserts, stay in IDLE until a valid load.
REQ-029 SHALL, on rst asserted mid-RUN, drop gen_clk to 0 immediately and start no new pulse after release.

Verification
REQ-030 SHALL cover: en=1, load with D=4, P=0 -> gen_clk period 4 cycles (2 high, 2 low); first high after posedge k+1; locked with first gen_rise; edge_cnt=3 after three rises.
REQ-031 SHALL cover: D=5, P=2 -> first high after posedge k+3; 3 high, 2 low; measured rise-to-rise period exactly 5 cycles.
REQ-032 SHALL cover: load D=1, then D=6 with P=6 -> err=1, gen_clk stays 0, locked=0; a following valid load clears err.
REQ-033 SHALL cover: in RUN with D=4, load D=8, P=1 -> gen_clk=0 next cycle, edge_cnt=0, new period 8 after 1-cycle align.
REQ-034 SHALL cover: en dropped mid-high with load simultaneously high -> IDLE, gen_clk=0 next cycle, edge_cnt held, load ignored.
REQ-035 SHALL cover: rst pulsed mid-RUN between clock edges -> gen_clk, locked, and edge_cnt are 0 immediately; no gen_rise until a new load.

Source files
------------

// File: rtl/clock_div_gen.sv
// clock_div_gen: programmable-period, phase-delayed clock generator with lock, error and rising-edge count.
module clock_div_gen #(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          master_clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [W-1:0]  div_in,
  input  logic [W-1:0]  phase_in,
  output logic          gen_clk,
  output logic          gen_rise,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] edge_cnt
);
  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;
  localparam logic [W-1:0] ONE = 1;
  state_t state, state_n;
  logic [W-1:0] d_q, p_q, cnt, d_n, p_n, cnt_n, high;
  logic gen_n, rise_n, lock_n, err_n, valid;
  logic [CW-1:0] ecnt_n;
  assign high  = (d_q >> 1) + {{(W-1){1'b0}}, d_q[0]};
  assign valid = (div_in >= 2) && (phase_in < div_in);
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    d_n     = d_q;
    p_n     = p_q;
    err_n   = err;
    ecnt_n  = edge_cnt;
    lock_n  = locked;
    gen_n   = 1'b0;
    rise_n  = 1'b0;
    if (!en) begin
      state_n = IDLE;
      lock_n  = 1'b0;
    end else if (load) begin
      lock_n = 1'b0;
      if (valid) begin
        d_n     = div_in;
        p_n     = phase_in;
        err_n   = 1'b0;
        ecnt_n  = '0;
        cnt_n   = '0;
        state_n = (phase_in != 0) ? ALIGN : RUN;
      end else begin
        err_n   = 1'b1;
        state_n = IDLE;
      end
    end else if (state == ALIGN) begin
      state_n = (cnt == p_q - ONE) ? RUN : ALIGN;
      cnt_n   = (cnt == p_q - ONE) ? '0 : cnt + ONE;
    end else if (state == RUN) begin
      gen_n  = cnt < high;
      cnt_n  = (cnt == d_q - ONE) ? '0 : cnt + ONE;
      rise_n = gen_n & ~gen_clk;
      ecnt_n = edge_cnt + CW'(rise_n);
      lock_n = locked | rise_n;
    end
  end
  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      d_q      <= '0;
      p_q      <= '0;
      gen_clk  <= 1'b0;
      gen_rise <= 1'b0;
      locked   <= 1'b0;
      err      <= 1'b0;
      edge_cnt <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      d_q      <= d_n;
      p_q      <= p_n;
      gen_clk  <= gen_n;
      gen_rise <= rise_n;
      locked   <= lock_n;
      err      <= err_n;
      edge_cnt <= ecnt_n;
    end
  end
endmodule
